// File: rtl/spi_master_ctrl.sv
// SPI master sharing clk with the slave: sends a 10-bit {cmd,payload} frame MSB-first
// under SS_n, and for read-data frames captures the returned RAM byte from MISO.
module spi_master_ctrl #(
    parameter int LEAD_CYC  = 2,
    parameter int TAIL_CYC  = 3,
    parameter int MISO_WAIT = 4,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int MAX_AB  = (LEAD_CYC > TAIL_CYC) ? LEAD_CYC : TAIL_CYC;
    localparam int MAX_CD  = (MISO_WAIT > GAP_CYC) ? MISO_WAIT : GAP_CYC;
    localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_CNT = (MAX_ABC > 10) ? MAX_ABC : 10;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_WAIT,
        S_SAMPLE,
        S_TAIL,
        S_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [9:0]    sh;
    logic [7:0]    rx;
    logic          rd_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '0;
            rx       <= '0;
            rd_frame <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh       <= {cmd, wdata};
                        rd_frame <= (cmd == 2'b11);
                        SS_n     <= 1'b0;
                        MOSI     <= cmd[1];
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (cnt == CW'(LEAD_CYC - 1)) begin
                        // First SHIFT cycle presents bit 9; sh then holds the remaining bits.
                        MOSI  <= sh[9];
                        sh    <= {sh[8:0], 1'b0};
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CW'(9)) begin
                        MOSI  <= 1'b0;
                        cnt   <= '0;
                        state <= rd_frame ? S_WAIT : S_TAIL;
                    end else begin
                        MOSI <= sh[9];
                        sh   <= {sh[8:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == CW'(MISO_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    rx <= {rx[6:0], MISO};
                    if (cnt == CW'(7)) begin
                        rd_data <= {rx[6:0], MISO};
                        cnt     <= '0;
                        state   <= S_TAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (cnt == CW'(TAIL_CYC - 1)) begin
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised bench for spi_master_ctrl: a behavioural SPI slave + RAM answers on MISO,
// and a scoreboard of expected frames is checked whenever the master pulses done.
`timescale 1ns/100ps
module tb_spi_master_ctrl;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    always #1 clk = ~clk;

    spi_master_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmd     (cmd),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] c;
        logic [7:0] d;
        int         len;
        logic [7:0] rd;
    } exp_t;

    exp_t sbq[$];

    // Reference model: what the RAM subsystem should contain after each issued command.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr;
    logic [7:0] ref_rd;
    int         issued = 0;

    function automatic void model_issue(input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        e.c   = c;
        e.d   = d;
        e.len = (c == 2'b11) ? 27 : 15;
        case (c)
            2'b00, 2'b10: ref_addr = d;
            2'b01:        ref_mem[ref_addr] = d;
            default:      ref_rd = ref_mem[ref_addr];
        endcase
        e.rd = ref_rd;
        sbq.push_back(e);
    endfunction

    // Behavioural slave: decodes what actually appeared on MOSI, answers on MISO.
    logic [7:0]  slv_mem [256];
    logic [7:0]  slv_addr;
    logic [7:0]  slv_ret;
    logic [9:0]  fbits;
    logic [31:0] pat;
    logic [31:0] last_pat;
    int          last_len;
    bit          have_frame = 1'b0;
    int          lowcnt = 0;
    int          highcnt = 100;
    int          dones = 0;

    always @(negedge clk) begin
        if (rst) begin
            lowcnt = 0;
            MISO   = 1'b0;
        end else if (!SS_n) begin
            if (lowcnt == 0) begin
                chk("gap_high", 32'(highcnt >= GAP), 32'd1);
                pat = '0;
            end
            pat = {pat[30:0], MOSI};
            if (lowcnt >= 2 && lowcnt < 12) fbits = {fbits[8:0], MOSI};
            if (lowcnt == 12) slv_ret = slv_mem[slv_addr];
            if (lowcnt >= 16 && lowcnt < 24 && fbits[9:8] == 2'b11)
                MISO = slv_ret[23 - lowcnt];
            else
                MISO = 1'($urandom);
            lowcnt++;
            highcnt = 0;
        end else begin
            if (lowcnt > 0) begin
                if (lowcnt >= 12) begin
                    case (fbits[9:8])
                        2'b00, 2'b10: slv_addr = fbits[7:0];
                        2'b01:        slv_mem[slv_addr] = fbits[7:0];
                        default:      ;
                    endcase
                    last_len   = lowcnt;
                    last_pat   = pat;
                    have_frame = 1'b1;
                end
                lowcnt = 0;
            end
            highcnt++;
            MISO = 1'($urandom);
            if (done) begin
                dones++;
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 32'(dones), 32'(issued));
                end else begin
                    exp_t e;
                    logic [31:0] ep;
                    e  = sbq.pop_front();
                    ep = 32'({e.c[1], e.c[1], e.c, e.d}) << (e.len - 12);
                    chk("frame_seen", 32'(have_frame), 32'd1);
                    chk("frame_len", 32'(last_len), 32'(e.len));
                    chk("mosi_bits", last_pat, ep);
                    chk("rd_data", 32'(rd_data), 32'(e.rd));
                    $display("frame cmd=%0d wdata=%02h len=%0d rd_data=%02h exp_rd=%02h",
                             e.c, e.d, last_len, rd_data, e.rd);
                end
                have_frame = 1'b0;
            end
        end
    end

    // Entered and left at a negedge with busy=0.
    task automatic run_txn(input logic [1:0] c, input logic [7:0] d, input int idle, input int noise);
        int n;
        int exp_len;
        start = 1'b0;
        repeat (idle) @(negedge clk);
        start = 1'b1;
        cmd   = c;
        wdata = d;
        model_issue(c, d);
        issued++;
        exp_len = (c == 2'b11) ? 27 : 15;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
            cmd   = 2'($urandom);
            wdata = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", 32'(n), 32'(exp_len + GAP));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        wdata = 8'h00;
        MISO  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            slv_mem[i] = 8'(i) ^ 8'h5A;
        end
        ref_addr = 8'h00;
        slv_addr = 8'h00;
        ref_rd   = 8'h00;
        fbits    = '0;
        pat      = '0;

        repeat (3) @(negedge clk);
        chk("reset_ss_n", 32'(SS_n), 32'd1);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(2'b00, 8'hAA, 0, 0);
        run_txn(2'b01, 8'hCC, 1, 0);
        run_txn(2'b10, 8'hAA, 0, 0);
        run_txn(2'b11, 8'h00, 0, 0);

        // Abort a write frame in LEAD: no done, SS_n released at once, rd_data cleared.
        start = 1'b1;
        cmd   = 2'b01;
        wdata = 8'h55;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before", 32'(busy), 32'd1);
        chk("abort_ss_n_before", 32'(SS_n), 32'd0);
        #0.5 rst = 1'b1;
        #0.3;
        chk("abort_ss_n", 32'(SS_n), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'd0);
        ref_rd = 8'h00;
        repeat (2) @(negedge clk);
        #0.5 rst = 1'b0;
        @(negedge clk);

        run_txn(2'b11, 8'h3C, 0, 1);
        run_txn(2'b01, 8'h77, 0, 2);
        run_txn(2'b11, 8'h00, 0, 2);
        run_txn(2'b10, 8'h10, 0, 2);

        repeat (40)
            run_txn(2'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));

        repeat (3) @(negedge clk);
        chk("done_count", 32'(dones), 32'(issued));
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
